// File: rtl/morse_pkg.sv
// Shared constants and state encoding for the Morse character display controller.
package morse_pkg;

    localparam logic [7:0] BLANK_SEG  = 8'hff;
    localparam int         NUM_DIGITS = 32'sd4;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        SCAN  = 1'b1
    } disp_state_e;

    // One-hot-low anode pattern for a digit index.
    function automatic logic [3:0] digit_en(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-scan divider: one-cycle tick every SCAN_DIV cycles while run is high.
module scan_tick_gen #(
    parameter int SCAN_DIV = 32'sd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int            CW   = (SCAN_DIV > 32'sd1) ? $clog2(SCAN_DIV) : 32'sd1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 32'sd1);

    logic [CW-1:0] div_cnt_r;
    logic          tick_s;

    // divider counter, parked at zero whenever scanning is not running
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_r <= {CW{1'b0}};
        end else if (!run) begin
            div_cnt_r <= {CW{1'b0}};
        end else if (div_cnt_r == LAST) begin
            div_cnt_r <= {CW{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + CW'(1'b1);
        end
    end

    // terminal-count decode
    always_comb begin
        tick_s = 1'b0;
        if (run && (div_cnt_r == LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/morse_disp_ctrl.sv
// Four-slot scrolling seven-segment display for decoded Morse characters,
// with a timed wipe phase and a sticky overflow dot on the leftmost digit.
module morse_disp_ctrl #(
    parameter int SCAN_DIV   = 32'sd50000,
    parameter int NUM_DIGITS = 32'sd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [7:0] char_seg,
    input  logic       clr,
    output logic       char_ready,
    output logic [7:0] seg,
    output logic [3:0] en,
    output logic       dot,
    output logic [2:0] fill
);

    import morse_pkg::*;

    disp_state_e state_r;
    logic [1:0]  wipe_cnt_r;
    logic [7:0]  slot_r [NUM_DIGITS];
    logic [2:0]  fill_r;
    logic        ovf_r;
    logic [1:0]  idx_r;
    logic [7:0]  seg_r;
    logic [3:0]  en_r;
    logic        dot_r;

    logic        ready_s;
    logic        accept_s;
    logic        run_s;
    logic        tick_s;
    logic [7:0]  seg_nxt_s;
    logic [3:0]  en_nxt_s;
    logic        dot_nxt_s;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (run_s),
        .tick (tick_s)
    );

    // handshake decode and next-cycle display values; a pending clr blanks immediately
    always_comb begin
        ready_s   = 1'b0;
        accept_s  = 1'b0;
        run_s     = 1'b0;
        seg_nxt_s = BLANK_SEG;
        en_nxt_s  = 4'b1111;
        dot_nxt_s = 1'b1;
        if (rst && (state_r == SCAN) && !clr) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        if (ready_s && char_valid && (char_seg != BLANK_SEG)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == SCAN) && !clr) begin
            run_s    = 1'b1;
            en_nxt_s = digit_en(idx_r);
            if ({1'b0, idx_r} < fill_r) begin
                seg_nxt_s = slot_r[idx_r];
            end else begin
                seg_nxt_s = BLANK_SEG;
            end
            if ((idx_r == 2'd3) && ovf_r) begin
                dot_nxt_s = 1'b0;
            end else begin
                dot_nxt_s = 1'b1;
            end
        end else begin
            run_s     = 1'b0;
            seg_nxt_s = BLANK_SEG;
            en_nxt_s  = 4'b1111;
            dot_nxt_s = 1'b1;
        end
    end

    // wipe/scan sequencing, slot shift register and registered display drive
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= CLEAR;
            wipe_cnt_r <= 2'd0;
            fill_r     <= 3'd0;
            ovf_r      <= 1'b0;
            idx_r      <= 2'd0;
            seg_r      <= BLANK_SEG;
            en_r       <= 4'b1111;
            dot_r      <= 1'b1;
        end else begin
            seg_r <= seg_nxt_s;
            en_r  <= en_nxt_s;
            dot_r <= dot_nxt_s;
            case (state_r)
                CLEAR: begin
                    slot_r[wipe_cnt_r] <= BLANK_SEG;
                    fill_r             <= 3'd0;
                    ovf_r              <= 1'b0;
                    idx_r              <= 2'd0;
                    if (clr) begin
                        wipe_cnt_r <= 2'd0;
                    end else if (wipe_cnt_r == 2'd3) begin
                        wipe_cnt_r <= 2'd0;
                        state_r    <= SCAN;
                    end else begin
                        wipe_cnt_r <= wipe_cnt_r + 2'd1;
                    end
                end
                SCAN: begin
                    if (clr) begin
                        state_r    <= CLEAR;
                        wipe_cnt_r <= 2'd0;
                        fill_r     <= 3'd0;
                        ovf_r      <= 1'b0;
                        idx_r      <= 2'd0;
                    end else begin
                        // newest character enters slot 0; slot 3 falls off when full
                        if (accept_s) begin
                            slot_r[3] <= slot_r[2];
                            slot_r[2] <= slot_r[1];
                            slot_r[1] <= slot_r[0];
                            slot_r[0] <= char_seg;
                            if (fill_r == 3'd4) begin
                                ovf_r <= 1'b1;
                            end else begin
                                fill_r <= fill_r + 3'd1;
                            end
                        end else begin
                            fill_r <= fill_r;
                        end
                        if (tick_s) begin
                            idx_r <= idx_r + 2'd1;
                        end else begin
                            idx_r <= idx_r;
                        end
                    end
                end
                default: begin
                    state_r    <= CLEAR;
                    wipe_cnt_r <= 2'd0;
                    fill_r     <= 3'd0;
                    ovf_r      <= 1'b0;
                    idx_r      <= 2'd0;
                end
            endcase
        end
    end

    assign char_ready = ready_s;
    assign seg        = seg_r;
    assign en         = en_r;
    assign dot        = dot_r;
    assign fill       = fill_r;

endmodule

// File: tb/tb_morse_disp_ctrl.sv
// Scoreboard bench for morse_disp_ctrl with a fast scan divider.
module tb_morse_disp_ctrl;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_seg = 8'hff;
    logic       clr = 1'b0;
    logic       char_ready;
    logic [7:0] seg;
    logic [3:0] en;
    logic       dot;
    logic [2:0] fill;

    typedef struct packed {
        logic [3:0] en;
        logic [7:0] seg;
        logic       dot;
        logic [2:0] fill;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] en_prev = 4'b1111;

    morse_disp_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_seg   (char_seg),
        .clr        (clr),
        .char_ready (char_ready),
        .seg        (seg),
        .en         (en),
        .dot        (dot),
        .fill       (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each newly presented digit is checked against the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if ((en !== en_prev) && (en !== 4'b1111) && (exp_q.size() > 0)) begin
            e = exp_q.pop_front();
            check("scan_en",   32'(en),   32'(e.en));
            check("scan_seg",  32'(seg),  32'(e.seg));
            check("scan_dot",  32'(dot),  32'(e.dot));
            check("scan_fill", 32'(fill), 32'(e.fill));
        end
        en_prev = en;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        step();
        char_valid = 1'b1;
        char_seg   = v;
        step();
        char_valid = 1'b0;
        char_seg   = 8'hff;
    endtask

    task automatic wait_en(input logic [3:0] tgt);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (en === tgt) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_en_timeout", 32'(found), 32'd1);
    endtask

    // Queue one full scan round (digits 0..3) starting at the next digit-0 presentation.
    task automatic push_round(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input logic [2:0] f, input logic d3);
        logic drained;
        wait_en(4'b0111);
        @(posedge clk);
        exp_q.push_back({4'b1110, s0, 1'b1, f});
        exp_q.push_back({4'b1101, s1, 1'b1, f});
        exp_q.push_back({4'b1011, s2, 1'b1, f});
        exp_q.push_back({4'b0111, s3, d3,   f});
        drained = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("round_drain", 32'(drained), 32'd1);
    endtask

    task automatic check_clear_phase(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_ready_low"}, 32'(char_ready), 32'd0);
            check({tag, "_en_off"},    32'(en),         32'hf);
            check({tag, "_seg_blank"}, 32'(seg),        32'hff);
            check({tag, "_fill_zero"}, 32'(fill),       32'd0);
        end
        @(negedge clk);
        check({tag, "_ready_high"}, 32'(char_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_en",    32'(en),         32'hf);
        check("rst_seg",   32'(seg),        32'hff);
        check("rst_dot",   32'(dot),        32'd1);
        check("rst_fill",  32'(fill),       32'd0);
        step();
        rst = 1'b1;
        check_clear_phase("rel");

        // two characters: newest on digit 0
        send(8'h08);
        send(8'h60);
        @(negedge clk);
        check("fill_two", 32'(fill), 32'd2);
        push_round(8'h60, 8'h08, 8'hff, 8'hff, 3'd2, 1'b1);

        // five more: saturate and overflow
        for (int v = 1; v <= 5; v++) begin
            send(8'(v));
        end
        @(negedge clk);
        check("fill_sat", 32'(fill), 32'd4);
        push_round(8'h05, 8'h04, 8'h03, 8'h02, 3'd4, 1'b0);

        // blank code is dropped
        send(8'hff);
        @(negedge clk);
        check("fill_blank_drop", 32'(fill), 32'd4);
        push_round(8'h05, 8'h04, 8'h03, 8'h02, 3'd4, 1'b0);

        // clr wins over a simultaneous character
        step();
        clr        = 1'b1;
        char_valid = 1'b1;
        char_seg   = 8'h11;
        @(negedge clk);
        check("clr_ready_low", 32'(char_ready), 32'd0);
        step();
        clr        = 1'b0;
        char_valid = 1'b0;
        char_seg   = 8'hff;
        check_clear_phase("clr");
        push_round(8'hff, 8'hff, 8'hff, 8'hff, 3'd0, 1'b1);

        // reset mid-scan with three characters
        send(8'h24);
        send(8'h30);
        send(8'h19);
        @(negedge clk);
        check("fill_three", 32'(fill), 32'd3);
        wait_en(4'b1101);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_en",    32'(en),         32'hf);
        check("mid_rst_fill",  32'(fill),       32'd0);
        check("mid_rst_seg",   32'(seg),        32'hff);
        check("mid_rst_ready", 32'(char_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_clear_ready", 32'(char_ready), 32'd0);
        end
        @(negedge clk);
        check("mid_rst_scan_ready", 32'(char_ready), 32'd1);
        check("mid_rst_scan_en",    32'(en),         32'hf);
        for (int i = 0; i < SCAN_DIV; i++) begin
            @(negedge clk);
            check("restart_idx0_en",  32'(en),  32'he);
            check("restart_idx0_seg", 32'(seg), 32'hff);
        end
        @(negedge clk);
        check("restart_idx1_en", 32'(en), 32'hd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
